mcdt_formatter: RTL and testbench
=================================

# mcdt_formatter

Downstream consumer of the multi-channel data transfer (mcdt) arbiter output. It sorts the mcdt output word stream (data, valid, id) into per-channel buffers. Once a channel has buffered a full frame of LEN words, the block emits a framed packet on a ready/valid output: one header word followed by LEN payload words. The mcdt output has no backpressure, so this block absorbs every valid word, drops words when a buffer is full, and flags the drop.

## Interface
Clock is `clk_i`. Reset is `rst_i`, synchronous and active-high; no other clock or reset exists.

Parameters:
- `LEN`, default 4: payload words per frame; range 1..DEPTH.
- `DEPTH`, default 16: words per channel buffer; must be a power of 2.

Ports:
- `clk_i`  input  1  clock
- `rst_i`  input  1  synchronous active-high reset
- `mcdt_data_i`  input  32  data word from mcdt
- `mcdt_val_i`  input  1  data word valid
- `mcdt_id_i`  input  2  source channel; 0..2 are legal, 3 is illegal
- `fmt_data_o`  output  32  header, payload or trailer word
- `fmt_valid_o`  output  1  `fmt_data_o` is valid
- `fmt_ready_i`  input  1  downstream accepts the word
- `fmt_sof_o`  output  1  current word is the header
- `fmt_eof_o`  output  1  current word is the last word of the frame
- `fmt_chid_o`  output  2  channel of the frame in flight
- `ovf_o`  output  3  sticky per-channel overflow
- `ovf_clr_i`  input  1  clears `ovf_o`
- `bad_id_o`  output  1  one-cycle pulse when a word with id 3 arrives

## Operation
- Input path:
  - On `mcdt_val_i` with id 0..2, the word is pushed into that channel's buffer.
  - If that buffer is full, the word is dropped and `ovf_o[id]` is set.
  - id 3: the word is dropped and `bad_id_o` pulses on the next cycle.
- A channel is eligible when its buffer holds at least LEN words.
- Arbitration is round-robin:
  - The search starts at the channel after the last granted one.
  - The pointer resets to channel 2, so channel 0 has first priority after reset.
- FSM states are IDLE, HDR, PAY, and TRL (TRL only exists when the checksum is compiled in).
  - IDLE: if any channel is eligible, latch the winner into `fmt_chid_o` and go to HDR; otherwise stay in IDLE.
  - HDR: drive the header with `fmt_sof_o`=1. On handshake, go to PAY and set the word counter to 0.
  - PAY: drive the head word of the granted buffer. On handshake, pop that word and increment the counter. At counter LEN-1 the handshake moves to TRL if compiled in, otherwise to IDLE.
- Header word format:
  - [31:24] = 8'hA5
  - [23:18] = 0
  - [17:16] = channel id
  - [15:0] = LEN
- Output signal behaviour:
  - `fmt_valid_o` is high in HDR, PAY and TRL.
  - Data and flags stay stable while `fmt_ready_i` is low.
  - `fmt_eof_o` is high on the final word of the frame.
- Simultaneous push and pop on the same buffer in one cycle are both performed, so the count is unchanged. A pop always frees space for a push in that same cycle, so a buffer that is full at the start of the cycle does not drop the incoming word if it is also popped.
- Frames never interleave. The arbitration decision is fixed until the frame completes.
- `ovf_clr_i` clears `ovf_o`. If a new overflow occurs in the same cycle, the set wins.

## Timing
- Reset values:
  - FSM in IDLE
  - all buffers empty
  - `fmt_valid_o`, `fmt_sof_o`, `fmt_eof_o`, `ovf_o` and `bad_id_o` all 0
  - `fmt_data_o` and `fmt_chid_o` both 0
  - round-robin pointer = 2
- Latency:
  - A word pushed at edge N counts toward eligibility from cycle N+1.
  - IDLE makes its decision in cycle N+1, and the header is valid in cycle N+2.
- Throughput: with `fmt_ready_i` held at 1, a frame occupies LEN+1 cycles (LEN+2 with the checksum) plus one IDLE cycle between frames.
- Reset mid-frame: on the next edge the output goes idle, the frame is abandoned and the buffers are flushed. No partial frame is resumed.
- Buffer counts are log2(DEPTH)+1 bits wide. Read and write pointers wrap modulo DEPTH.

## Configuration
- `MCDT_FMT_CHKSUM_EN` defined:
  - After the payload the block adds a trailer word in state TRL, equal to the XOR of the LEN payload words.
  - `fmt_eof_o` is asserted on the trailer.
  - Header bit [23] = 1 to indicate a trailer follows.
- `MCDT_FMT_CHKSUM_EN` undefined:
  - TRL and the XOR accumulator are absent.
  - `fmt_eof_o` is asserted on the last payload word.
  - Header bit [23] = 0.

## Structure
- Package `mcdt_fmt_pkg` contains:
  - the state enum (IDLE, HDR, PAY, TRL)
  - the header magic 8'hA5
  - the header field positions
  - a header-build function
- Sub-module `mcdt_fmt_fifo` is a synchronous FIFO parameterized by DEPTH, with push, pop, full, empty and count. It is instantiated once per channel (3 instances).
- The top level contains the input demux, the round-robin arbiter, the FSM, the word counter and the overflow logic.

## Test plan
- Push 4 words C0_0000..C0_0003 on id 0 with `fmt_ready_i`=1 and LEN=4. The output must be header 32'hA500_0004, then the 4 words in order; `fmt_sof_o` on the header and `fmt_eof_o` on C0_0003.
- Fill channels 0, 1 and 2 with 4 words each in the same burst. Frames must come out in the order ch0, ch1, ch2. Refill all three: the order must be ch0, ch1, ch2 again, because round-robin resumes after ch2.
- Hold `fmt_ready_i`=0 for 5 cycles in the middle of the payload. `fmt_data_o` must stay stable, and no word may be lost or duplicated.
- Push 17 words into ch1 with DEPTH=16 and `fmt_ready_i`=0. The 17th word is dropped and `ovf_o`=3'b010. Pulse `ovf_clr_i`: `ovf_o` returns to 0.
- Send a word with id 3. `bad_id_o` pulses once, and no buffer count changes.
- Assert `rst_i` in the middle of a frame. Next cycle `fmt_valid_o`=0. After reset is released, a fresh 4-word push yields a complete frame. With `MCDT_FMT_CHKSUM_EN` defined, the trailer equals the XOR of the 4 payload words.

Source files
------------

// File: rtl/mcdt_fmt_pkg.sv
// Shared types, header layout and header builder for the mcdt output formatter.
package mcdt_fmt_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_HDR, ST_PAY, ST_TRL} fmt_state_e;

  localparam int         NCH           = 3;
  localparam logic [7:0] HDR_MAGIC     = 8'hA5;
  localparam int         HDR_MAGIC_LSB = 24;
  localparam int         HDR_TRL_BIT   = 23;
  localparam int         HDR_CH_LSB    = 16;
  localparam int         HDR_LEN_LSB   = 0;

  function automatic logic [31:0] build_hdr(input logic [1:0] ch, input logic [15:0] len,
                                            input logic trl);
    logic [31:0] h;
    h = '0;
    h[HDR_MAGIC_LSB +: 8] = HDR_MAGIC;
    h[HDR_TRL_BIT]        = trl;
    h[HDR_CH_LSB +: 2]    = ch;
    h[HDR_LEN_LSB +: 16]  = len;
    return h;
  endfunction

endpackage

// File: rtl/mcdt_fmt_if.sv
// Framed ready/valid output stream of the mcdt formatter.
interface mcdt_fmt_if;
  logic [31:0] fmt_data_o;
  logic        fmt_valid_o;
  logic        fmt_ready_i;
  logic        fmt_sof_o;
  logic        fmt_eof_o;
  logic [1:0]  fmt_chid_o;

  modport master (output fmt_data_o, fmt_valid_o, fmt_sof_o, fmt_eof_o, fmt_chid_o,
                  input  fmt_ready_i);
  modport slave  (input  fmt_data_o, fmt_valid_o, fmt_sof_o, fmt_eof_o, fmt_chid_o,
                  output fmt_ready_i);
endinterface

// File: rtl/mcdt_fmt_fifo.sv
// Per-channel synchronous FIFO; pointers wrap modulo DEPTH (power of 2), count is log2(DEPTH)+1 bits.
module mcdt_fmt_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [W-1:0]           data_i,
  output logic [W-1:0]           data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign count_o = cnt_q;
  assign data_o  = mem_q[rd_q];

  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (do_push) wr_d = wr_q + AW'(1);
    if (do_pop)  rd_d = rd_q + AW'(1);
    if (do_push && !do_pop)      cnt_d = cnt_q + (AW+1)'(1);
    else if (!do_push && do_pop) cnt_d = cnt_q - (AW+1)'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end

endmodule

// File: rtl/mcdt_formatter.sv
// Sorts the mcdt word stream into per-channel FIFOs and emits round-robin framed packets.
// Optional trailer (XOR of payload) compiled in with MCDT_FMT_CHKSUM_EN.
module mcdt_formatter #(
  parameter int LEN   = 4,
  parameter int DEPTH = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] mcdt_data_i,
  input  logic        mcdt_val_i,
  input  logic [1:0]  mcdt_id_i,
  mcdt_fmt_if.master  fmt,
  output logic [2:0]  ovf_o,
  input  logic        ovf_clr_i,
  output logic        bad_id_o
);
  import mcdt_fmt_pkg::*;

  localparam int CW = $clog2(DEPTH) + 1;
`ifdef MCDT_FMT_CHKSUM_EN
  localparam logic CHK_EN = 1'b1;
`else
  localparam logic CHK_EN = 1'b0;
`endif

  fmt_state_e             state_q, state_d;
  logic [1:0]             chid_q, chid_d, rr_q, rr_d, win;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [NCH-1:0]         ovf_q, ovf_d, ovf_set, push, pop, full, empty, elig;
  logic                   bad_q, bad_d, found, last;
  logic [NCH-1:0][31:0]   head;
  logic [NCH-1:0][CW-1:0] count;
  logic [31:0]            data_c;
  logic                   valid_c, sof_c, eof_c;
`ifdef MCDT_FMT_CHKSUM_EN
  logic [31:0]            xor_q, xor_d;
`endif

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    assign push[c]    = mcdt_val_i && (mcdt_id_i == 2'(c)) && (!full[c] || pop[c]);
    assign ovf_set[c] = mcdt_val_i && (mcdt_id_i == 2'(c)) && full[c] && !pop[c];
    assign elig[c]    = (count[c] >= CW'(LEN));

    mcdt_fmt_fifo #(.DEPTH(DEPTH), .W(32)) u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (push[c]),
      .pop_i   (pop[c]),
      .data_i  (mcdt_data_i),
      .data_o  (head[c]),
      .full_o  (full[c]),
      .empty_o (empty[c]),
      .count_o (count[c])
    );
  end

  // Search starts one past the last grant and wraps over the three channels.
  always_comb begin
    found = 1'b0;
    win   = rr_q;
    for (int i = 1; i <= NCH; i++) begin
      if (!found && elig[(int'(rr_q) + i) % NCH]) begin
        found = 1'b1;
        win   = 2'((int'(rr_q) + i) % NCH);
      end
    end
  end

  assign last  = (cnt_q == CW'(LEN - 1));
  assign bad_d = mcdt_val_i && (mcdt_id_i == 2'd3);
  assign ovf_d = (ovf_q & ~{NCH{ovf_clr_i}}) | ovf_set;

  always_comb begin
    state_d = state_q;
    chid_d  = chid_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    pop     = '0;
    data_c  = '0;
    valid_c = 1'b0;
    sof_c   = 1'b0;
    eof_c   = 1'b0;
`ifdef MCDT_FMT_CHKSUM_EN
    xor_d   = xor_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (found) begin
          state_d = ST_HDR;
          chid_d  = win;
          rr_d    = win;
        end
      end
      ST_HDR: begin
        valid_c = 1'b1;
        sof_c   = 1'b1;
        data_c  = build_hdr(chid_q, 16'(LEN), CHK_EN);
        if (fmt.fmt_ready_i) begin
          state_d = ST_PAY;
          cnt_d   = '0;
`ifdef MCDT_FMT_CHKSUM_EN
          xor_d   = '0;
`endif
        end
      end
      ST_PAY: begin
        valid_c = 1'b1;
        data_c  = head[chid_q];
        eof_c   = last && !CHK_EN;
        if (fmt.fmt_ready_i) begin
          pop[chid_q] = !empty[chid_q];
          cnt_d       = cnt_q + CW'(1);
`ifdef MCDT_FMT_CHKSUM_EN
          xor_d       = xor_q ^ head[chid_q];
          if (last) state_d = ST_TRL;
`else
          if (last) state_d = ST_IDLE;
`endif
        end
      end
`ifdef MCDT_FMT_CHKSUM_EN
      ST_TRL: begin
        valid_c = 1'b1;
        eof_c   = 1'b1;
        data_c  = xor_q;
        if (fmt.fmt_ready_i) state_d = ST_IDLE;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      chid_q  <= 2'd0;
      rr_q    <= 2'd2;
      cnt_q   <= '0;
      ovf_q   <= '0;
      bad_q   <= 1'b0;
`ifdef MCDT_FMT_CHKSUM_EN
      xor_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      chid_q  <= chid_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      bad_q   <= bad_d;
`ifdef MCDT_FMT_CHKSUM_EN
      xor_q   <= xor_d;
`endif
    end
  end

  assign fmt.fmt_data_o  = data_c;
  assign fmt.fmt_valid_o = valid_c;
  assign fmt.fmt_sof_o   = sof_c;
  assign fmt.fmt_eof_o   = eof_c;
  assign fmt.fmt_chid_o  = chid_q;
  assign ovf_o           = ovf_q;
  assign bad_id_o        = bad_q;

endmodule

// File: tb/tb_mcdt_formatter.sv
// Directed + randomized bench for mcdt_formatter; reference is per-channel word queues.
module tb_mcdt_formatter;
  localparam int LEN   = 4;
  localparam int DEPTH = 16;
`ifdef MCDT_FMT_CHKSUM_EN
  localparam logic CHKBIT = 1'b1;
`else
  localparam logic CHKBIT = 1'b0;
`endif

  logic        clk, rst;
  logic [31:0] mcdt_data;
  logic        mcdt_val;
  logic [1:0]  mcdt_id;
  logic [2:0]  ovf;
  logic        ovf_clr, bad_id;

  mcdt_fmt_if fif ();

  mcdt_formatter #(.LEN(LEN), .DEPTH(DEPTH)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .mcdt_data_i (mcdt_data),
    .mcdt_val_i  (mcdt_val),
    .mcdt_id_i   (mcdt_id),
    .fmt         (fif),
    .ovf_o       (ovf),
    .ovf_clr_i   (ovf_clr),
    .bad_id_o    (bad_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] mq [3][$];
  int          rr_m     = 2;
  int          first_ch = -1;
  logic [2:0]  movf     = 3'b000;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_hdr(input int ch);
    return {8'hA5, CHKBIT, 5'b0, 2'(ch), 16'(LEN)};
  endfunction

  // Next frame: the first channel to reach LEN words, otherwise round-robin after the last grant.
  function automatic int pick();
    if (first_ch >= 0) return first_ch;
    for (int i = 1; i <= 3; i++)
      if (mq[(rr_m + i) % 3].size() >= LEN) return (rr_m + i) % 3;
    return -1;
  endfunction

  task automatic push(input logic [1:0] id, input logic [31:0] d);
    mcdt_val  = 1'b1;
    mcdt_id   = id;
    mcdt_data = d;
    @(posedge clk); #1;
    mcdt_val  = 1'b0;
    if (id != 2'd3) begin
      if (mq[id].size() < DEPTH) begin
        mq[id].push_back(d);
        if (mq[id].size() == LEN && first_ch < 0) first_ch = int'(id);
      end else begin
        movf[id] = 1'b1;
      end
    end
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 64 && !ok; i++) begin
      @(negedge clk);
      ok = fif.fmt_valid_o;
    end
    if (!ok) chk("valid_timeout", 32'(fif.fmt_valid_o), 32'd1);
  endtask

  task automatic drain(input int stall_idx);
    int          ch, sidx;
    bit          ok;
    logic [31:0] exp_w [$];
`ifdef MCDT_FMT_CHKSUM_EN
    logic [31:0] x;
`endif
    sidx = stall_idx;
    fif.fmt_ready_i = 1'b1;
    ch = pick();
    while (ch >= 0) begin
      first_ch = -1;
      exp_w.delete();
      exp_w.push_back(exp_hdr(ch));
`ifdef MCDT_FMT_CHKSUM_EN
      x = '0;
      for (int i = 0; i < LEN; i++) x ^= mq[ch][i];
`endif
      for (int i = 0; i < LEN; i++) exp_w.push_back(mq[ch].pop_front());
`ifdef MCDT_FMT_CHKSUM_EN
      exp_w.push_back(x);
`endif
      for (int k = 0; k < exp_w.size(); k++) begin
        wait_valid(ok);
        if (!ok) begin
          for (int c = 0; c < 3; c++) mq[c].delete();
          return;
        end
        if (k == sidx) begin
          fif.fmt_ready_i = 1'b0;
          repeat (5) begin
            @(negedge clk);
            chk("stall_data", fif.fmt_data_o, exp_w[k]);
            chk("stall_valid", 32'(fif.fmt_valid_o), 32'd1);
          end
          fif.fmt_ready_i = 1'b1;
        end
        chk("data", fif.fmt_data_o, exp_w[k]);
        chk("sof", 32'(fif.fmt_sof_o), 32'(k == 0));
        chk("eof", 32'(fif.fmt_eof_o), 32'(k == exp_w.size() - 1));
        chk("chid", 32'(fif.fmt_chid_o), 32'(ch));
        @(posedge clk); #1;
      end
      sidx = -1;
      rr_m = ch;
      ch   = pick();
    end
    @(negedge clk);
    chk("idle_after", 32'(fif.fmt_valid_o), 32'd0);
    chk("ovf_model", 32'(ovf), 32'(movf));
  endtask

  initial begin
    rst = 1'b1; mcdt_val = 1'b0; mcdt_id = 2'd0; mcdt_data = '0;
    ovf_clr = 1'b0; fif.fmt_ready_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 32'(fif.fmt_valid_o), 32'd0);
    chk("rst_sof",   32'(fif.fmt_sof_o),   32'd0);
    chk("rst_eof",   32'(fif.fmt_eof_o),   32'd0);
    chk("rst_data",  fif.fmt_data_o,       32'd0);
    chk("rst_chid",  32'(fif.fmt_chid_o),  32'd0);
    chk("rst_ovf",   32'(ovf),             32'd0);
    chk("rst_bad",   32'(bad_id),          32'd0);
    rst = 1'b0;

    // single frame on ch0 with ready high, header latency
    fif.fmt_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) push(2'd0, 32'h00C0_0000 + 32'(i));
    chk("hdr_lat_idle", 32'(fif.fmt_valid_o), 32'd0);
    @(posedge clk); #1;
    chk("hdr_lat_valid", 32'(fif.fmt_valid_o), 32'd1);
    chk("hdr_word", fif.fmt_data_o, 32'hA500_0004 | (32'(CHKBIT) << 23));
    drain(-1);

    // three channels filled in one burst, twice
    for (int r = 0; r < 2; r++) begin
      fif.fmt_ready_i = 1'b0;
      for (int i = 0; i < 4; i++)
        for (int c = 0; c < 3; c++) push(2'(c), {8'(c), 8'(r), 16'(i)});
      drain(-1);
    end

    // backpressure for 5 cycles mid-payload
    fif.fmt_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) push(2'd1, $urandom);
    drain(2);

    // overflow on ch1, clear, and set-beats-clear
    fif.fmt_ready_i = 1'b0;
    repeat (17) push(2'd1, $urandom);
    chk("ovf_set", 32'(ovf), 32'b010);
    ovf_clr = 1'b1; @(posedge clk); #1; ovf_clr = 1'b0; movf = '0;
    chk("ovf_clr", 32'(ovf), 32'd0);
    ovf_clr = 1'b1; push(2'd1, $urandom); ovf_clr = 1'b0;
    chk("ovf_set_wins", 32'(ovf), 32'b010);
    ovf_clr = 1'b1; @(posedge clk); #1; ovf_clr = 1'b0; movf = '0;
    chk("ovf_clr2", 32'(ovf), 32'd0);

    // illegal id: one-cycle pulse, buffers untouched (ch1 drains exactly 16 words)
    push(2'd3, 32'hDEAD_BEEF);
    chk("bad_pulse", 32'(bad_id), 32'd1);
    @(posedge clk); #1;
    chk("bad_clear", 32'(bad_id), 32'd0);
    drain(-1);

    // random traffic
    fif.fmt_ready_i = 1'b0;
    repeat (24) push(2'($urandom_range(0, 2)), $urandom);
    drain(-1);

    // reset mid-frame
    fif.fmt_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) push(2'd2, $urandom);
    fif.fmt_ready_i = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_valid", 32'(fif.fmt_valid_o), 32'd0);
    chk("midrst_data", fif.fmt_data_o, 32'd0);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) mq[c].delete();
    rr_m = 2; first_ch = -1; movf = '0;
    for (int i = 0; i < 4; i++) push(2'd0, $urandom);
    drain(-1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
